// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock, MSB first.
// Result is {remainder, quotient}, held while the requester keeps start_i high.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0]   rem_q, dvd_q, dvs_q;
  logic                sgn_q, neg1_q, neg2_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                accept, done, ge;
  logic [DATA_W-1:0]   abs1, abs2, rem_nxt, q_fix, r_fix;
  logic [DATA_W:0]     shifted;
  logic [2*DATA_W-1:0] result_d;
  logic                ready_d;

  assign accept = (state == DivFree) && start_i && !annul_i;
  assign done   = (cnt_q == CNT_W'(DATA_W));

  assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Partial remainder is always < divisor, so the shifted value fits DATA_W+1 bits
  assign shifted = {rem_q, dvd_q[DATA_W-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  assign rem_nxt = ge ? DATA_W'(shifted - {1'b0, dvs_q}) : shifted[DATA_W-1:0];

  // Quotient sign follows the operand signs; remainder follows the dividend
  assign q_fix = (sgn_q && (neg1_q ^ neg2_q)) ? -dvd_q : dvd_q;
  assign r_fix = (sgn_q && neg1_q) ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DivFree;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DivFree:   if (accept) state_nxt = (opdata2_i == '0) ? DivByZero : DivOn;
      DivByZero: state_nxt = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i)   state_nxt = DivFree;
        else if (done) state_nxt = DivEnd;
      end
      DivEnd:    if (annul_i || !start_i) state_nxt = DivFree;
      default:   state_nxt = DivFree;
    endcase
  end

  always_comb begin
    result_d = result_o;
    ready_d  = ready_o;
    case (state)
      DivFree: begin
        result_d = '0;
        ready_d  = 1'b0;
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = !annul_i;
      end
      DivOn: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (!annul_i && done) begin
          result_d = {r_fix, q_fix};
          ready_d  = 1'b1;
        end
      end
      DivEnd: begin
        if (annul_i || !start_i) begin
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      result_o <= result_d;
      ready_o  <= ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      sgn_q  <= 1'b0;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      cnt_q  <= '0;
    end else if (accept && opdata2_i != '0) begin
      rem_q  <= '0;
      dvd_q  <= abs1;
      dvs_q  <= abs2;
      sgn_q  <= signed_div_i;
      neg1_q <= opdata1_i[DATA_W-1];
      neg2_q <= opdata2_i[DATA_W-1];
      cnt_q  <= '0;
    end else if (state != DivFree && annul_i) begin
      cnt_q <= '0;
    end else if (state == DivOn && !done) begin
      rem_q <= rem_nxt;
      dvd_q <= {dvd_q[DATA_W-2:0], ge};
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
